// File: rtl/master_port_pkg.sv
// master_port_pkg: shared bus package.
// FSM state encoding, default widths, slave-ID constants.
package master_port_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 255;

  localparam int               SLV_W    = 2;
  localparam logic [SLV_W-1:0] SLV_NONE = 2'd0;

  typedef enum logic [2:0] {
    IDLE,
    SEL,
    WAIT_GNT,
    ADDR,
    WDATA,
    RDATA,
    DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_port_serial.sv
// serial_shift: right-shift register, parallel load, serial in at MSB.
// clk/rst, load+din (parallel load), shift+sin (shift), q (contents).
module serial_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         shift,
  input  logic         sin,
  output logic [W-1:0] q
);

  logic [W-1:0] q_shr;

  // LSB leaves first; a bit shifted in lands at the MSB, so after
  // W shifts the first bit received sits at q[0].
  always_comb begin
    q_shr        = q >> 1;
    q_shr[W-1]   = sin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= q_shr;
    end
  end

endmodule

// File: rtl/master_port.sv
// master_port: serial bus master, one command -> one single-beat transfer.
// cmd_* user side, rsp_* completion, m_* serial bus and arbiter side.
module master_port
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [SLV_W-1:0]      cmd_slave,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  m_request,
  output logic                  m_slave_sel,
  input  logic                  m_grant,
  output logic                  m_master_valid,
  output logic                  m_master_ready,
  output logic                  m_tx_address,
  output logic                  m_tx_data,
  input  logic                  m_rx_data,
  output logic                  m_write_en,
  output logic                  m_read_en,
  input  logic                  m_slave_valid,
  input  logic                  m_slave_ready,
  output logic                  m_tx_burst_num,
  output logic                  trans_done
);

  localparam int BCW = $clog2(max2(ADDR_WIDTH, DATA_WIDTH) + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);
  localparam int TXW = ADDR_WIDTH + DATA_WIDTH;

  localparam logic [BCW-1:0] A_LAST = BCW'(ADDR_WIDTH - 1);
  localparam logic [BCW-1:0] D_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] S_LAST = BCW'(SLV_W - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [BCW-1:0]          bcnt_q, bcnt_d;
  logic [TCW-1:0]          tcnt_q, tcnt_d;
  logic                    err_q, err_d;
  logic                    write_q;
  logic [SLV_W-1:0]        slave_q;
  logic [DATA_WIDTH-1:0]   rsp_q;
  logic                    latch;
  logic                    tx_shift, rx_shift;
  logic                    tmo;
  logic                    xfer;
  logic [TXW-1:0]          tx_q;
  logic [DATA_WIDTH-1:0]   rx_q;
  logic                    unused_tx_hi;

  // TX holds {wdata, addr}: address bits go out first, data follows.
  serial_shift #(.W(TXW)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .load  (latch),
    .din   ({cmd_wdata, cmd_addr}),
    .shift (tx_shift),
    .sin   (1'b0),
    .q     (tx_q)
  );

  // Cleared on accept so writes and rejected commands report 0.
  serial_shift #(.W(DATA_WIDTH)) u_rx (
    .clk   (clk),
    .rst   (rst),
    .load  (latch),
    .din   ('0),
    .shift (rx_shift),
    .sin   (m_rx_data),
    .q     (rx_q)
  );

  assign unused_tx_hi = |tx_q[TXW-1:1];

  assign tmo = (tcnt_q == T_LAST);

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    err_d    = err_q;
    latch    = 1'b0;
    tx_shift = 1'b0;
    rx_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          latch   = 1'b1;
          bcnt_d  = '0;
          tcnt_d  = '0;
          err_d   = (cmd_slave == SLV_NONE);
          state_d = (cmd_slave == SLV_NONE) ? DONE : SEL;
        end
      end
      SEL: begin
        if (bcnt_q == S_LAST) begin
          bcnt_d  = '0;
          state_d = WAIT_GNT;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      WAIT_GNT: begin
        if (m_grant) begin
          tcnt_d  = '0;
          state_d = ADDR;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ADDR, WDATA, RDATA: begin
        if ((state_q == RDATA) ? m_slave_valid : m_slave_ready) begin
          tx_shift = (state_q != RDATA);
          rx_shift = (state_q == RDATA);
          tcnt_d   = '0;
          bcnt_d   = bcnt_q + 1'b1;
          if (state_q == ADDR && bcnt_q == A_LAST) begin
            bcnt_d  = '0;
            state_d = write_q ? WDATA : RDATA;
          end else if (state_q != ADDR && bcnt_q == D_LAST) begin
            bcnt_d  = '0;
            state_d = DONE;
          end
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
      slave_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
      if (latch) begin
        write_q <= cmd_write;
        slave_q <= cmd_slave;
      end
      if (state_q == DONE) begin
        rsp_q <= rx_q;
      end
    end
  end

  assign xfer           = state_q inside {ADDR, WDATA, RDATA};
  assign cmd_ready      = (state_q == IDLE);
  assign m_request      = xfer || state_q inside {SEL, WAIT_GNT};
  assign m_slave_sel    = (state_q == SEL) && slave_q[bcnt_q[0]];
  assign m_master_valid = state_q inside {ADDR, WDATA};
  assign m_master_ready = (state_q == RDATA);
  assign m_tx_address   = (state_q == ADDR) && tx_q[0];
  assign m_tx_data      = (state_q == WDATA) && tx_q[0];
  assign m_write_en     = xfer && write_q;
  assign m_read_en      = xfer && !write_q;
  assign m_tx_burst_num = 1'b0;
  assign rsp_valid      = (state_q == DONE);
  assign trans_done     = (state_q == DONE);
  assign rsp_error      = (state_q == DONE) && err_q;
  // Live value during DONE, then held until the next DONE.
  assign rsp_rdata      = (state_q == DONE) ? rx_q : rsp_q;

endmodule

// File: tb/tb_master_port.sv
// tb_master_port: randomized transfers against a latency/data model.
// Bench acts as arbiter and slave with scheduled stall/gap counts.
module tb_master_port;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [1:0]    cmd_slave;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          m_request, m_slave_sel, m_grant;
  logic          m_master_valid, m_master_ready;
  logic          m_tx_address, m_tx_data, m_rx_data;
  logic          m_write_en, m_read_en;
  logic          m_slave_valid, m_slave_ready;
  logic          m_tx_burst_num, trans_done;
  logic [11:0]   bus_out;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  master_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_slave      (cmd_slave),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .m_request      (m_request),
    .m_slave_sel    (m_slave_sel),
    .m_grant        (m_grant),
    .m_master_valid (m_master_valid),
    .m_master_ready (m_master_ready),
    .m_tx_address   (m_tx_address),
    .m_tx_data      (m_tx_data),
    .m_rx_data      (m_rx_data),
    .m_write_en     (m_write_en),
    .m_read_en      (m_read_en),
    .m_slave_valid  (m_slave_valid),
    .m_slave_ready  (m_slave_ready),
    .m_tx_burst_num (m_tx_burst_num),
    .trans_done     (trans_done)
  );

  assign bus_out = {m_request, m_slave_sel, m_master_valid,
                    m_master_ready, m_tx_address, m_tx_data,
                    m_write_en, m_read_en, m_tx_burst_num,
                    trans_done, rsp_valid, rsp_error};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // gw: cycle after accept (minus 2) on which a one-cycle grant is given.
  // fix: stall/gap per bit (-1 = random 0..3). tmo_bit: bit stalled TMO
  // cycles. rst_bit: address bit on which reset is pulsed.
  task automatic run_txn(input logic          wr,
                         input logic [1:0]    slv,
                         input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd,
                         input int            gw,
                         input int            fix,
                         input int            tmo_bit,
                         input int            rst_bit);
    int            stall [AW+DW+1];
    int            lat, k, bi, st;
    logic          err, got, aborted, req_seen, bus_ok;
    logic [AW-1:0] a_got;
    logic [DW-1:0] d_got, rexp;
    logic [1:0]    sel_got;

    foreach (stall[i])
      stall[i] = (fix >= 0) ? fix : int'($urandom_range(3));
    if (tmo_bit >= 0) stall[tmo_bit] = TMO;

    err = 1'b0;
    lat = 1;
    if (slv == 2'd0) begin
      err = 1'b1;
    end else if (gw > TMO) begin
      err = 1'b1;
      lat = 2 + TMO + 1;
    end else begin
      lat = 2 + gw;
      for (int i = 0; i < AW + DW; i++) begin
        if (stall[i] >= TMO) begin
          lat += TMO;
          err = 1'b1;
          break;
        end
        lat += stall[i] + 1;
      end
      lat += 1;
    end
    rexp = wr ? '0 : rd;

    for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    check("cmd_ready", 32'(cmd_ready), 1);
    cmd_write = wr;
    cmd_slave = slv;
    cmd_addr  = addr;
    cmd_wdata = wd;
    cmd_valid = 1'b1;

    k = 0; bi = 0; st = stall[0];
    got = 0; aborted = 0; req_seen = 0; bus_ok = 1;
    a_got = '0; d_got = '0; sel_got = '0;
    while (!got && !aborted && k < 2000) begin
      @(negedge clk);
      k++;
      cmd_valid     = 1'b0;
      m_grant       = 1'b0;
      m_slave_ready = 1'b0;
      m_slave_valid = 1'b0;
      m_rx_data     = 1'b0;
      req_seen |= m_request;
      if (k <= 2) sel_got[k-1] = m_slave_sel;
      if ((m_master_valid || m_master_ready) &&
          (m_write_en !== wr || m_read_en !== !wr))
        bus_ok = 1'b0;
      if (m_tx_burst_num !== 1'b0) bus_ok = 1'b0;
      if (rsp_valid) begin
        got = 1'b1;
      end else if (rst_bit >= 0 && bi == rst_bit && m_master_valid) begin
        rst     = 1'b1;
        aborted = 1'b1;
      end else begin
        m_grant = (k == 2 + gw);
        if (m_master_valid || m_master_ready) begin
          if (st > 0) begin
            st--;
          end else begin
            if (m_master_valid) begin
              m_slave_ready = 1'b1;
              if (bi < AW) a_got[bi] = m_tx_address;
              else d_got[bi-AW] = m_tx_data;
            end else begin
              m_slave_valid = 1'b1;
              m_rx_data     = rd[bi-AW];
            end
            bi++;
            st = (bi <= AW + DW) ? stall[bi] : 0;
          end
        end
      end
    end

    if (aborted) begin
      @(negedge clk);
      check("rst_ready", 32'(cmd_ready), 1);
      check("rst_bus", 32'(bus_out), 0);
      check("rst_rdata", 32'(rsp_rdata), 0);
      rst = 1'b0;
    end else if (!got) begin
      check("rsp_wait", 32'(got), 1);
    end else begin
      check("latency", k, lat);
      check("error", 32'(rsp_error), 32'(err));
      check("trans_done", 32'(trans_done), 1);
      check("req_done", 32'({m_request, m_master_valid}), 0);
      check("bus_en", 32'(bus_ok), 1);
      if (!err) begin
        check("addr", 32'(a_got), 32'(addr));
        check("sel", 32'(sel_got), 32'(slv));
        check("rdata", 32'(rsp_rdata), 32'(rexp));
        if (wr) check("wdata", 32'(d_got), 32'(wd));
      end
      if (slv == 2'd0) check("no_req", 32'(req_seen), 0);
      @(negedge clk);
      check("one_shot", 32'({rsp_valid, trans_done}), 0);
      check("back_idle", 32'(cmd_ready), 1);
      if (!err) check("rdata_hold", 32'(rsp_rdata), 32'(rexp));
    end
  endtask

  initial begin
    rst           = 1'b1;
    cmd_valid     = 1'b0;
    cmd_write     = 1'b0;
    cmd_slave     = '0;
    cmd_addr      = '0;
    cmd_wdata     = '0;
    m_grant       = 1'b0;
    m_rx_data     = 1'b0;
    m_slave_valid = 1'b0;
    m_slave_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(cmd_ready), 1);
    check("reset_bus", 32'(bus_out), 0);
    check("reset_rdata", 32'(rsp_rdata), 0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(1'b1, 2'd2, 12'h0A5, 8'h3C, 8'h00, 3, 0, -1, -1);
    run_txn(1'b0, 2'd1, 12'h123, 8'h00, 8'h81, 1, 1, -1, -1);
    run_txn(1'b1, 2'd3, 12'h0F0, 8'h55, 8'h00, 300, 0, -1, -1);
    run_txn(1'b1, 2'd0, 12'h001, 8'h11, 8'h00, 1, 0, -1, -1);
    run_txn(1'b1, 2'd2, 12'h5A5, 8'hA5, 8'h00, 2, 0, -1, 5);
    run_txn(1'b1, 2'd1, 12'hFFF, 8'hFF, 8'h00, 1, 0, -1, -1);
    run_txn(1'b1, 2'd3, 12'h3C3, 8'h77, 8'h00, 2, 0, 5, -1);
    run_txn(1'b0, 2'd2, 12'h800, 8'h00, 8'hE7, 1, 0, AW + 3, -1);

    for (int n = 0; n < 25; n++) begin
      logic [1:0] s;
      s = ($urandom_range(9) == 0) ? 2'd0 : 2'($urandom_range(3, 1));
      run_txn(1'($urandom_range(1)), s, AW'($urandom), DW'($urandom),
              DW'($urandom), int'($urandom_range(6, 1)), -1, -1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
